// File: rtl/spi_master_cfg_pkg.sv
// Shared constants for the configurable SPI master: register map, CTRL bit
// positions, version word and controller state encodings.
package spi_master_cfg_pkg;

  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_DIV     = 3'd1;
  localparam logic [2:0] ADDR_SSEL    = 3'd2;
  localparam logic [2:0] ADDR_LEN     = 3'd3;
  localparam logic [2:0] ADDR_TX      = 3'd4;
  localparam logic [2:0] ADDR_RX      = 3'd5;
  localparam logic [2:0] ADDR_STATUS  = 3'd6;
  localparam logic [2:0] ADDR_VERSION = 3'd7;

  localparam int CTRL_CPHA  = 0;
  localparam int CTRL_CPOL  = 1;
  localparam int CTRL_LSB   = 2;
  localparam int CTRL_INTEN = 3;

  localparam logic [7:0] VERSION = 8'h21;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_XFER  = 2'd2,
    ST_TRAIL = 2'd3
  } spi_state_t;

endpackage

// File: rtl/spi_clkgen.sv
// SPI clock generator: down-counting half-period timer, sclk toggle and
// leading/trailing edge strobes aligned with the clk edge that moves sclk.
module spi_clkgen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_int,
  input  logic             run,
  input  logic             toggle,
  input  logic             cpol,
  input  logic [DIV_W-1:0] div,
  output logic             sclk,
  output logic             tick,
  output logic             lead_edge,
  output logic             trail_edge
);

  logic [DIV_W-1:0] cnt;

  assign tick       = run && (cnt == '0);
  assign lead_edge  = tick && toggle && (sclk == cpol);
  assign trail_edge = tick && toggle && (sclk != cpol);

  // While stopped the timer preloads so the first half-period is full length.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!run) begin
      cnt  <= div;
      sclk <= cpol;
    end else begin
      if (tick) cnt <= div;
      else      cnt <= cnt - 1'b1;
      if (tick && toggle) sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/spi_master_cfg.sv
// Register-configured SPI master: bus register file, frame FSM and shift
// registers; sclk timing comes from spi_clkgen.
//
//   state    | meaning
//   ST_IDLE  | no frame, ss released, waiting for TX write
//   ST_LEAD  | ss asserted, one half-period before first sclk edge
//   ST_XFER  | 2*(LEN+1) sclk edges, shift/sample on strobes
//   ST_TRAIL | sclk at CPOL, one half-period before ss release
module spi_master_cfg
  import spi_master_cfg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NSS    = 4,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_int,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic [2:0]        address,
  input  logic              sel,
  input  logic              read,
  input  logic              write,
  output logic              interrupt,
  output logic              sclk,
  output logic [NSS-1:0]    ss,
  output logic              mosi,
  input  logic              miso
);

  localparam int LEN_W  = $clog2(DATA_W);
  localparam int ECNT_W = LEN_W + 1;
  localparam int SSEL_W = 8;
  localparam logic [DATA_W-1:0] LEN_MAX = DATA_W'(DATA_W - 1);
  localparam logic [LEN_W-1:0]  TOP_IDX = LEN_W'(DATA_W - 1);

  spi_state_t state_q, state_d;

  logic [3:0]        ctrl_q;
  logic [DIV_W-1:0]  div_q;
  logic [SSEL_W-1:0] ssel_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] tx_q, rx_q, tx_sr, rx_sr;
  logic [ECNT_W-1:0] edge_cnt;
  logic              ready_q, ovr_q;

  logic wr_en, rd_en, wr_tx, rd_rx, busy, start, done;
  logic cpha, cpol, lsb_first, int_en, last_edge;
  logic run, toggle, tick, lead_edge, trail_edge;
  logic shift_ev, sample_ev;
  logic [LEN_W-1:0]  pad;
  logic [DATA_W-1:0] tx_align;

  function automatic logic [DATA_W-1:0] sr_next(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic out_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  assign wr_en     = sel && write;
  assign rd_en     = sel && read;
  assign wr_tx     = wr_en && (address == ADDR_TX);
  assign rd_rx     = rd_en && (address == ADDR_RX);
  assign busy      = (state_q != ST_IDLE);
  assign start     = wr_tx && !busy;
  assign cpha      = ctrl_q[CTRL_CPHA];
  assign cpol      = ctrl_q[CTRL_CPOL];
  assign lsb_first = ctrl_q[CTRL_LSB];
  assign int_en    = ctrl_q[CTRL_INTEN];
  assign last_edge = (edge_cnt == '0);
  assign interrupt = int_en && ready_q;

  // MSB-first frames are pre-aligned so bit LEN always leaves from the top.
  assign pad       = TOP_IDX - len_q;
  assign tx_align  = lsb_first ? data_in : (data_in << pad);

  assign shift_ev  = cpha ? lead_edge : (trail_edge && !last_edge);
  assign sample_ev = cpha ? trail_edge : lead_edge;

  assign ss = (busy && (ssel_q < SSEL_W'(NSS))) ? ~(NSS'(1) << ssel_q) : '1;

  spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clk        (clk),
    .rst_int    (rst_int),
    .run        (run),
    .toggle     (toggle),
    .cpol       (cpol),
    .div        (div_q),
    .sclk       (sclk),
    .tick       (tick),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge)
  );

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    run     = 1'b1;
    toggle  = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        run = 1'b0;
        if (start) state_d = ST_LEAD;
      end
      ST_LEAD: begin
        if (tick) state_d = ST_XFER;
      end
      ST_XFER: begin
        toggle = 1'b1;
        if (tick && last_edge) state_d = ST_TRAIL;
      end
      ST_TRAIL: begin
        if (tick) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      ctrl_q   <= '0;
      div_q    <= '0;
      ssel_q   <= '0;
      len_q    <= TOP_IDX;
      tx_q     <= '0;
      rx_q     <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      edge_cnt <= '0;
      ready_q  <= 1'b0;
      ovr_q    <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      if (wr_en && !busy) begin
        case (address)
          ADDR_CTRL: ctrl_q <= data_in[3:0];
          ADDR_DIV:  div_q  <= data_in[DIV_W-1:0];
          ADDR_SSEL: ssel_q <= data_in[SSEL_W-1:0];
          ADDR_LEN:  len_q  <= (data_in > LEN_MAX) ? TOP_IDX : data_in[LEN_W-1:0];
          default: ;
        endcase
      end

      if (rd_rx) begin
        ready_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
      if (wr_tx && busy) ovr_q <= 1'b1;

      // CPHA=0 puts the first bit on mosi now; CPHA=1 waits for the first leading edge.
      if (start) begin
        tx_q     <= data_in;
        rx_sr    <= '0;
        edge_cnt <= {len_q, 1'b1};
        ready_q  <= 1'b0;
        if (cpha) begin
          tx_sr <= tx_align;
        end else begin
          tx_sr <= sr_next(tx_align, lsb_first);
          mosi  <= out_bit(tx_align, lsb_first);
        end
      end

      if ((state_q == ST_XFER) && tick && !last_edge) edge_cnt <= edge_cnt - 1'b1;

      if (shift_ev) begin
        mosi  <= out_bit(tx_sr, lsb_first);
        tx_sr <= sr_next(tx_sr, lsb_first);
      end

      if (sample_ev) begin
        if (lsb_first) rx_sr <= {miso, rx_sr[DATA_W-1:1]};
        else           rx_sr <= {rx_sr[DATA_W-2:0], miso};
      end

      if (done) begin
        ready_q <= 1'b1;
        mosi    <= 1'b0;
        rx_q    <= lsb_first ? (rx_sr >> pad) : rx_sr;
      end
    end
  end

  always_comb begin
    data_out = '0;
    if (rd_en) begin
      case (address)
        ADDR_CTRL:    data_out = DATA_W'(ctrl_q);
        ADDR_DIV:     data_out = DATA_W'(div_q);
        ADDR_SSEL:    data_out = DATA_W'(ssel_q);
        ADDR_LEN:     data_out = DATA_W'(len_q);
        ADDR_TX:      data_out = tx_q;
        ADDR_RX:      data_out = rx_q;
        ADDR_STATUS:  data_out = DATA_W'({ovr_q, busy, ready_q});
        ADDR_VERSION: data_out = DATA_W'(VERSION);
        default:      data_out = '0;
      endcase
    end
  end

endmodule
